// File: rtl/deskew_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | deskew_pkg: shared one-hot state codes, default sizes and width helper.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package deskew_pkg;

  localparam int c_DEFAULT_N_LANES  = 20;
  localparam int c_DEFAULT_MAX_SKEW = 16;

  localparam int c_STATE_W = 5;
  localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 5'b00001;
  localparam logic [c_STATE_W-1:0] c_ST_SCAN    = 5'b00010;
  localparam logic [c_STATE_W-1:0] c_ST_PROGRAM = 5'b00100;
  localparam logic [c_STATE_W-1:0] c_ST_DONE    = 5'b01000;
  localparam logic [c_STATE_W-1:0] c_ST_ERROR   = 5'b10000;

  // One extra bit so an out-of-range count (== MAX_SKEW) stays representable.
  function automatic int f_count_width(input int max_skew);
    return $clog2(max_skew) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/deskew_stall_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | deskew_stall_timer: counts stalled write cycles, flags the LIMIT-th one. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module deskew_stall_timer #(
  parameter int LIMIT = 15
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int NB = $clog2(LIMIT + 1);
  localparam logic [NB-1:0] c_LAST = NB'(LIMIT - 1);

  logic [NB-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + NB'(1);
    end
  end

  assign o_expired = i_inc && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/deskew_delay_programmer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | deskew_delay_programmer: snapshots lane counters, finds the max, then    |
// | programs each lane FIFO delay. Optional macro: DESKEW_PROG_TIMEOUT_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module deskew_delay_programmer
  import deskew_pkg::*;
#(
  parameter int N_LANES     = c_DEFAULT_N_LANES,
  parameter int MAX_SKEW    = c_DEFAULT_MAX_SKEW,
  parameter int NB_COUNT    = f_count_width(MAX_SKEW),
  parameter int NB_LANE_ID  = $clog2(N_LANES),
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_resync,
  input  logic                        i_set_fifo_delay,
  input  logic [N_LANES*NB_COUNT-1:0] i_lane_counters,
  input  logic                        i_wr_ready,
  output logic                        o_wr_valid,
  output logic [NB_LANE_ID-1:0]       o_wr_lane,
  output logic [NB_COUNT-1:0]         o_wr_delay,
  output logic [NB_COUNT-1:0]         o_max_skew,
  output logic                        o_busy,
  output logic                        o_program_done,
  output logic                        o_program_error
);

  localparam logic [NB_LANE_ID-1:0] c_LAST_LANE = NB_LANE_ID'(N_LANES - 1);
  localparam logic [NB_COUNT-1:0]   c_SKEW_LIM  = NB_COUNT'(MAX_SKEW);

  logic [c_STATE_W-1:0]  r_state;
  logic [c_STATE_W-1:0]  w_state_next;
  logic [NB_COUNT-1:0]   r_snap [N_LANES];
  logic [NB_COUNT-1:0]   r_max;
  logic [NB_COUNT-1:0]   r_max_skew;
  logic [NB_LANE_ID-1:0] r_idx;

  logic                  w_abort;
  logic                  w_trigger;
  logic                  w_in_program;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_timeout;
  logic [NB_COUNT-1:0]   w_cur;
  logic [NB_COUNT-1:0]   w_max_next;

  assign w_abort      = i_reset || i_resync;
  assign w_trigger    = i_set_fifo_delay && i_enable;
  assign w_in_program = (r_state == c_ST_PROGRAM);
  assign w_xfer       = w_in_program && i_enable && i_wr_ready;
  assign w_last       = (r_idx == c_LAST_LANE);
  assign w_cur        = r_snap[r_idx];
  assign w_max_next   = (w_cur > r_max) ? w_cur : r_max;

`ifdef DESKEW_PROG_TIMEOUT_EN
  logic w_stall_inc;
  logic w_stall_clear;

  assign w_stall_inc   = w_in_program && i_enable && !i_wr_ready;
  assign w_stall_clear = !w_in_program || w_xfer;

  deskew_stall_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_stall_timer (
    .i_clock   (i_clock),
    .i_reset   (w_abort),
    .i_clear   (w_stall_clear),
    .i_inc     (w_stall_inc),
    .o_expired (w_timeout)
  );
`else
  // Constant false; the reference keeps the parameter live in this build.
  assign w_timeout = (ACK_TIMEOUT < 0);
`endif

  always_ff @(posedge i_clock) begin
    if (w_abort) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_DONE, c_ST_ERROR: begin
        if (w_trigger) w_state_next = c_ST_SCAN;
      end
      c_ST_SCAN: begin
        if (i_enable && w_last) begin
          w_state_next = (w_max_next >= c_SKEW_LIM) ? c_ST_ERROR : c_ST_PROGRAM;
        end
      end
      c_ST_PROGRAM: begin
        if (w_xfer && w_last) begin
          w_state_next = c_ST_DONE;
        end else if (w_timeout) begin
          w_state_next = c_ST_ERROR;
        end
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy          = (r_state == c_ST_SCAN) || w_in_program;
    o_program_done  = (r_state == c_ST_DONE);
    o_program_error = (r_state == c_ST_ERROR);
    o_wr_valid      = w_in_program && i_enable;
    o_wr_lane       = w_in_program ? r_idx : '0;
    o_wr_delay      = w_in_program ? (r_max - w_cur) : '0;
  end

  assign o_max_skew = r_max_skew;

  always_ff @(posedge i_clock) begin
    if (w_abort) begin
      r_idx      <= '0;
      r_max      <= '0;
      r_max_skew <= '0;
      for (int k = 0; k < N_LANES; k++) r_snap[k] <= '0;
    end else if (i_enable) begin
      case (r_state)
        c_ST_IDLE, c_ST_DONE, c_ST_ERROR: begin
          if (i_set_fifo_delay) begin
            r_idx <= '0;
            r_max <= '0;
            for (int k = 0; k < N_LANES; k++) begin
              r_snap[k] <= i_lane_counters[k*NB_COUNT +: NB_COUNT];
            end
          end
        end
        c_ST_SCAN: begin
          r_max <= w_max_next;
          if (w_last) begin
            r_idx      <= '0;
            r_max_skew <= w_max_next;
          end else begin
            r_idx <= r_idx + NB_LANE_ID'(1);
          end
        end
        c_ST_PROGRAM: begin
          if (w_xfer) r_idx <= w_last ? '0 : r_idx + NB_LANE_ID'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deskew_delay_programmer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_deskew_delay_programmer: directed stimulus with a queue scoreboard.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_deskew_delay_programmer;

  localparam int N_LANES     = 4;
  localparam int MAX_SKEW    = 16;
  localparam int NB_COUNT    = 5;
  localparam int NB_LANE_ID  = 2;
  localparam int ACK_TIMEOUT = 15;

  logic                        clk = 1'b0;
  logic                        i_reset = 1'b1;
  logic                        i_enable = 1'b1;
  logic                        i_resync = 1'b0;
  logic                        i_set_fifo_delay = 1'b0;
  logic [N_LANES*NB_COUNT-1:0] i_lane_counters = '0;
  logic                        i_wr_ready = 1'b1;
  logic                        o_wr_valid;
  logic [NB_LANE_ID-1:0]       o_wr_lane;
  logic [NB_COUNT-1:0]         o_wr_delay;
  logic [NB_COUNT-1:0]         o_max_skew;
  logic                        o_busy;
  logic                        o_program_done;
  logic                        o_program_error;

  always #5 clk = ~clk;

  deskew_delay_programmer #(
    .N_LANES     (N_LANES),
    .MAX_SKEW    (MAX_SKEW),
    .NB_COUNT    (NB_COUNT),
    .NB_LANE_ID  (NB_LANE_ID),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .i_resync         (i_resync),
    .i_set_fifo_delay (i_set_fifo_delay),
    .i_lane_counters  (i_lane_counters),
    .i_wr_ready       (i_wr_ready),
    .o_wr_valid       (o_wr_valid),
    .o_wr_lane        (o_wr_lane),
    .o_wr_delay       (o_wr_delay),
    .o_max_skew       (o_max_skew),
    .o_busy           (o_busy),
    .o_program_done   (o_program_done),
    .o_program_error  (o_program_error)
  );

  typedef struct {
    int lane;
    int delay;
    int cyc;
  } exp_t;

  exp_t wq[$];
  int   dq[$];
  int   eq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  function automatic logic [N_LANES*NB_COUNT-1:0] pack(input int l0, l1, l2, l3);
    return {NB_COUNT'(l3), NB_COUNT'(l2), NB_COUNT'(l1), NB_COUNT'(l0)};
  endfunction

  task automatic push_w(input int lane, input int delay, input int c);
    exp_t e;
    e.lane = lane; e.delay = delay; e.cyc = c;
    wq.push_back(e);
  endtask

  task automatic trigger(input logic [N_LANES*NB_COUNT-1:0] cnt, output int t);
    t = cyc;
    i_lane_counters  = cnt;
    i_set_fifo_delay = 1'b1;
    tick();
    i_set_fifo_delay = 1'b0;
  endtask

  task automatic wait_end(input string name);
    for (int i = 0; i < 60 && !(o_program_done || o_program_error); i++) tick();
    check({name, "_finished"}, 32'(o_program_done || o_program_error), 1);
    tick();
  endtask

  task automatic push_basic(input int t);
    push_w(0, 4, t + 5);
    push_w(1, 7, t + 6);
    push_w(2, 0, t + 7);
    push_w(3, 5, t + 8);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or status edge.
  bit prev_done = 1'b0;
  bit prev_err  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!i_reset && !i_resync) begin
      if (!i_enable) check("gated_valid", 32'(o_wr_valid), 0);
      if (o_wr_valid && i_wr_ready) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = wq.pop_front();
          check("wr_lane", 32'(o_wr_lane), e.lane);
          check("wr_delay", 32'(o_wr_delay), e.delay);
          check("wr_cycle", cyc, e.cyc);
        end
      end else if (o_wr_valid && wq.size() != 0) begin
        check("held_lane", 32'(o_wr_lane), wq[0].lane);
        check("held_delay", 32'(o_wr_delay), wq[0].delay);
      end
      if (o_program_done && !prev_done) begin
        if (dq.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cyc, dq.pop_front());
      end
      if (o_program_error && !prev_err) begin
        if (eq.size() == 0) check("unexpected_error", 1, 0);
        else check("error_cycle", cyc, eq.pop_front());
      end
    end
    prev_done = o_program_done;
    prev_err  = o_program_error;
  end

  initial begin
    int t;
    logic [N_LANES*NB_COUNT-1:0] basic;
    basic = pack(3, 0, 7, 2);

    // Reset state
    repeat (3) tick();
    check("rst_valid", 32'(o_wr_valid), 0);
    check("rst_lane", 32'(o_wr_lane), 0);
    check("rst_delay", 32'(o_wr_delay), 0);
    check("rst_max", 32'(o_max_skew), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_program_done), 0);
    check("rst_error", 32'(o_program_error), 0);
    i_reset = 1'b0;
    tick();

    // Basic programming
    push_basic(cyc);
    dq.push_back(cyc + 9);
    trigger(basic, t);
    check("scan_busy", 32'(o_busy), 1);
    wait_end("basic");
    check("basic_max", 32'(o_max_skew), 7);

    // Backpressure on lane 1
    t = cyc;
    push_w(0, 4, t + 5);
    push_w(1, 7, t + 9);
    push_w(2, 0, t + 10);
    push_w(3, 5, t + 11);
    dq.push_back(t + 12);
    trigger(basic, t);
    goto(t + 6);
    i_wr_ready = 1'b0;
    goto(t + 9);
    i_wr_ready = 1'b1;
    wait_end("backpressure");

    // Out-of-range skew
    eq.push_back(cyc + 5);
    trigger(pack(0, 16, 1, 2), t);
    wait_end("oor");
    check("oor_max", 32'(o_max_skew), 16);
    check("oor_busy", 32'(o_busy), 0);

    // Abort after the lane-1 transfer, then reprogram from lane 0
    t = cyc;
    push_w(0, 4, t + 5);
    push_w(1, 7, t + 6);
    trigger(basic, t);
    goto(t + 7);
    i_resync = 1'b1;
    goto(t + 8);
    i_resync = 1'b0;
    check("abort_valid", 32'(o_wr_valid), 0);
    check("abort_busy", 32'(o_busy), 0);
    check("abort_done", 32'(o_program_done), 0);
    check("abort_error", 32'(o_program_error), 0);
    check("abort_max", 32'(o_max_skew), 0);
    check("abort_lane", 32'(o_wr_lane), 0);
    push_basic(cyc);
    dq.push_back(cyc + 9);
    trigger(basic, t);
    wait_end("reprogram");

    // Enable gating: 2 cycles in SCAN, 2 in PROGRAM
    t = cyc;
    push_w(0, 4, t + 7);
    push_w(1, 7, t + 8);
    push_w(2, 0, t + 11);
    push_w(3, 5, t + 12);
    dq.push_back(t + 13);
    trigger(basic, t);
    goto(t + 2);
    i_enable = 1'b0;
    goto(t + 4);
    i_enable = 1'b1;
    goto(t + 9);
    i_enable = 1'b0;
    goto(t + 11);
    i_enable = 1'b1;
    wait_end("enable");

    // Ready stuck low
    i_wr_ready = 1'b0;
`ifdef DESKEW_PROG_TIMEOUT_EN
    eq.push_back(cyc + 20);
    trigger(basic, t);
    wait_end("timeout");
    check("timeout_valid", 32'(o_wr_valid), 0);
`else
    trigger(basic, t);
    goto(t + 40);
    check("stall_busy", 32'(o_busy), 1);
    check("stall_valid", 32'(o_wr_valid), 1);
    check("stall_error", 32'(o_program_error), 0);
    i_resync = 1'b1;
    tick();
    i_resync = 1'b0;
`endif
    i_wr_ready = 1'b1;
    tick();

    check("sb_writes_left", wq.size(), 0);
    check("sb_done_left", dq.size(), 0);
    check("sb_error_left", eq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
